// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between fetch and load/store, one transaction at a time
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, RESP} state_t;
    typedef enum logic [1:0] {NONE, OWN_IF, OWN_D} owner_t;
    state_t            r_state;
    owner_t            r_owner;
    logic [3:0]        r_streak;
    logic [7:0]        r_timer;
    logic              r_we;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              w_idle;
    logic              w_d_win;
    logic              w_if_win;
    // data wins unless fetch is waiting and data has used up its streak
    assign w_idle   = (r_state == IDLE) && !rst;
    assign w_d_win  = w_idle && d_req && (!if_req || r_streak < 4'(MAX_D_STREAK));
    assign w_if_win = w_idle && if_req && !w_d_win;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_owner  <= NONE;
            r_streak <= '0;
            r_timer  <= '0;
            r_we     <= 1'b0;
            r_size   <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_d_win) begin
                        r_state  <= REQ;
                        r_owner  <= OWN_D;
                        r_we     <= d_we;
                        r_size   <= d_size;
                        r_addr   <= d_addr;
                        r_wdata  <= d_wdata;
                        r_streak <= !if_req ? 4'd0 :
                                    r_streak < 4'(MAX_D_STREAK) ? r_streak + 4'd1 : r_streak;
                    end else if (w_if_win) begin
                        r_state  <= REQ;
                        r_owner  <= OWN_IF;
                        r_we     <= 1'b0;
                        r_size   <= 2'b10;
                        r_addr   <= if_addr;
                        r_wdata  <= '0;
                        r_streak <= '0;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        r_state <= WAIT_RESP;
                        r_timer <= '0;
                    end
                end
                WAIT_RESP: begin
                    r_timer <= r_timer + 8'd1;
                    if (mem_rvalid) begin
                        r_state <= RESP;
                        r_rdata <= mem_rdata;
                        r_err   <= 1'b0;
                    end else if (r_timer == 8'(TIMEOUT - 1)) begin
                        r_state <= RESP;
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_owner <= NONE;
                end
            endcase
        end
    end
    assign if_gnt    = w_if_win;
    assign d_gnt     = w_d_win;
    assign mem_req   = r_state == REQ;
    assign mem_we    = mem_req & r_we;
    assign mem_size  = mem_req ? r_size : '0;
    assign mem_addr  = mem_req ? r_addr : '0;
    assign mem_wdata = mem_req ? r_wdata : '0;
    assign if_rvalid = (r_state == RESP) && (r_owner == OWN_IF);
    assign d_rvalid  = (r_state == RESP) && (r_owner == OWN_D);
    assign if_rdata  = if_rvalid ? r_rdata : '0;
    assign d_rdata   = d_rvalid ? r_rdata : '0;
    assign if_err    = if_rvalid & r_err;
    assign d_err     = d_rvalid & r_err;
    assign busy      = r_state != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, handshake, streak limit, timeout and reset abort
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;
    int          n_checks = 0;
    int          n_errors = 0;
    always #5 clk = ~clk;
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .busy(busy)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // from REQ: grant at once, answer in the next cycle; returns positioned in RESP
    task automatic run_txn(input logic [31:0] rd);
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        #1;
    endtask
    initial begin
        int bad;
        rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_size = 0; d_addr = 0;
        d_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_outs", {if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_req, mem_we, busy}, 0);
        chk("rst_data", {if_rdata, d_rdata}, 0);
        chk("rst_mem", {mem_size, mem_addr, mem_wdata}, 0);
        // fetch only
        if_req = 1; if_addr = 32'h100;
        #1;
        chk("f_gnt", {if_gnt, d_gnt}, 2'b10);
        tick();
        if_req = 0;
        #1;
        chk("f_req", {mem_req, mem_we, mem_size, mem_addr}, {1'b1, 1'b0, 2'b10, 32'h100});
        run_txn(32'h00A0_0093);
        chk("f_rsp", {if_rvalid, if_err, d_rvalid, if_rdata}, {3'b100, 32'h00A0_0093});
        tick();
        chk("f_idle", busy, 0);
        // simultaneous requests: data first, then fetch
        if_req = 1; if_addr = 32'h300;
        d_req = 1; d_we = 1; d_size = 2'b00; d_addr = 32'h2003; d_wdata = 32'hFF;
        #1;
        chk("s_gnt", {if_gnt, d_gnt}, 2'b01);
        tick();
        d_req = 0;
        #1;
        chk("s_req", {mem_req, mem_we, mem_size, mem_addr, mem_wdata}, {2'b11, 2'b00, 32'h2003, 32'hFF});
        chk("s_nognt", {if_gnt, d_gnt}, 0);
        run_txn(32'hDEAD);
        chk("s_rsp", {d_rvalid, if_rvalid, if_gnt, d_err}, 4'b1000);
        tick();
        chk("s_fgnt", {if_gnt, d_gnt}, 2'b10);
        tick();
        if_req = 0;
        #1;
        chk("s_faddr", mem_addr, 32'h300);
        run_txn(32'h1234);
        chk("s_frsp", {if_rvalid, if_rdata}, {1'b1, 32'h1234});
        tick();
        // both requesters held continuously: D,D,D,D,I repeating
        if_req = 1; if_addr = 32'h400; d_req = 1; d_we = 0; d_size = 2'b10; d_addr = 32'h800;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("order_%0d", i), {d_gnt, if_gnt}, (i % 5 != 4) ? 2'b10 : 2'b01);
            tick();
            run_txn(32'(i));
            tick();
        end
        if_req = 0; d_req = 0;
        #1;
        // timeout: no rvalid ever
        d_req = 1; d_we = 0; d_size = 2'b10; d_addr = 32'h40;
        #1;
        chk("t_gnt", d_gnt, 1);
        tick();
        d_req = 0;
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        bad = 0;
        for (int i = 1; i < 64; i++) begin
            tick();
            if (d_rvalid || !busy) bad++;
        end
        chk("t_early", bad, 0);
        tick();
        chk("t_rsp", {d_rvalid, d_err, if_rvalid, busy, d_rdata}, {4'b1101, 32'h0});
        tick();
        chk("t_idle", busy, 0);
        // rvalid in the timeout cycle wins
        d_req = 1;
        #1;
        tick();
        d_req = 0;
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        repeat (63) tick();
        mem_rvalid = 1; mem_rdata = 32'h77;
        tick();
        mem_rvalid = 0; mem_rdata = 0;
        #1;
        chk("tb_rsp", {d_rvalid, d_err, d_rdata}, {2'b10, 32'h77});
        tick();
        // memory withholds gnt for 10 cycles
        d_req = 1; d_we = 1; d_size = 2'b01; d_addr = 32'h1234; d_wdata = 32'hCAFEBABE;
        #1;
        tick();
        d_req = 0;
        #1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if ({mem_req, mem_we, mem_size, mem_addr, mem_wdata} !== {2'b11, 2'b01, 32'h1234, 32'hCAFEBABE}) bad++;
            if (i < 9) tick();
        end
        chk("w_stable", bad, 0);
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        #1;
        chk("w_xfree", {mem_req, mem_we, mem_size, mem_addr, mem_wdata}, 0);
        mem_rvalid = 1; mem_rdata = 32'h55;
        tick();
        mem_rvalid = 0; mem_rdata = 0;
        #1;
        chk("w_rsp", {d_rvalid, d_err, d_rdata}, {2'b10, 32'h55});
        tick();
        // reset during WAIT_RESP, then a late rvalid
        if_req = 1; if_addr = 32'h600;
        #1;
        tick();
        if_req = 0;
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        tick();
        rst = 1;
        tick();
        rst = 0; mem_rvalid = 1; mem_rdata = 32'h99;
        #1;
        chk("r_outs", {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, busy, if_rdata}, 0);
        tick();
        mem_rvalid = 0; mem_rdata = 0;
        #1;
        chk("r_norsp", {if_rvalid, d_rvalid, busy}, 0);
        if_req = 1; if_addr = 32'h700;
        #1;
        chk("r_fgnt", if_gnt, 1);
        tick();
        if_req = 0;
        #1;
        chk("r_faddr", {mem_req, mem_addr}, {1'b1, 32'h700});
        run_txn(32'h1111);
        chk("r_frsp", {if_rvalid, if_err, if_rdata}, {2'b10, 32'h1111});
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
